// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the ID-stage hazard logic of the 5-stage RISC-V core.
//   hazard_state_e : load-use stall FSM states (IDLE, LD_STALL)
//   REG_ZERO       : architectural zero register index (x0)
//   DEF_REG_AW     : default register address width
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam int DEF_REG_AW = 5;
  localparam int REG_ZERO   = 0;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    LD_STALL = 1'b1
  } hazard_state_e;

endpackage : hazard_pkg

// File: rtl/hazard_match.sv
// ---------------------------------------------------------------------------
// hazard_match
// Combinational producer-vs-consumer register comparator. Reports a match
// when the producing register is not x0 and equals an operand that the
// consuming instruction actually reads. Shared with the forwarding unit.
// Ports:
//   rd        in  REG_AW  destination register of the producer
//   rs1, rs2  in  REG_AW  source registers of the consumer
//   rs1_used  in  1       consumer reads rs1
//   rs2_used  in  1       consumer reads rs2
//   match     out 1       dependency exists
// ---------------------------------------------------------------------------
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  output logic              match
);

  logic rd_nonzero;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so writes to it never create a dependency.
  always_comb begin
    rd_nonzero = (rd != REG_AW'(REG_ZERO));
    rs1_hit    = rs1_used && (rd == rs1);
    rs2_hit    = rs2_used && (rd == rs2);
    match      = rd_nonzero && (rs1_hit || rs2_hit);
  end

endmodule : hazard_match

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
// ID-stage pipeline control: multi-cycle load-use stall, whole-pipe freeze on
// data-memory busy, taken-branch IF/ID flush and a stall-cycle counter.
// Priority: reset > DMem busy > load-use stall > branch > normal.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   ID_EX_MemRead_i         EX instruction is a load
//   ID_EX_RegisterRd_i      EX destination register
//   IF_ID_RegisterRs1/2_i   ID source registers
//   IF_ID_Rs1Used/Rs2Used_i ID instruction reads rs1/rs2
//   Branch_Taken_i          branch resolved taken in ID
//   DMem_Busy_i             data memory not ready
//   PCWrite_o, IF_ID_Write_o  fetch-side enables
//   ID_EX_Flush_o           bubble into ID/EX
//   IF_ID_Flush_o           squash IF/ID instruction
//   Pipe_Freeze_o           hold ID/EX, EX/MEM, MEM/WB
//   Stall_Cycles_o          load-use stall cycle count (wrapping)
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = DEF_REG_AW,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ID_EX_MemRead_i,
  input  logic [REG_AW-1:0] ID_EX_RegisterRd_i,
  input  logic [REG_AW-1:0] IF_ID_RegisterRs1_i,
  input  logic [REG_AW-1:0] IF_ID_RegisterRs2_i,
  input  logic              IF_ID_Rs1Used_i,
  input  logic              IF_ID_Rs2Used_i,
  input  logic              Branch_Taken_i,
  input  logic              DMem_Busy_i,
  output logic              PCWrite_o,
  output logic              IF_ID_Write_o,
  output logic              ID_EX_Flush_o,
  output logic              IF_ID_Flush_o,
  output logic              Pipe_Freeze_o,
  output logic [CNT_W-1:0]  Stall_Cycles_o
);

  localparam int            REM_W    = $clog2(LOAD_LAT + 1);
  localparam logic [REM_W-1:0] REM_LOAD = REM_W'(LOAD_LAT - 1);
  localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);

  hazard_state_e    state;
  logic [REM_W-1:0] rem;
  logic [CNT_W-1:0] stall_cnt;
  logic             reg_match;
  logic             hit;
  logic             stall;

  hazard_match #(
    .REG_AW (REG_AW)
  ) u_match (
    .rd       (ID_EX_RegisterRd_i),
    .rs1      (IF_ID_RegisterRs1_i),
    .rs2      (IF_ID_RegisterRs2_i),
    .rs1_used (IF_ID_Rs1Used_i),
    .rs2_used (IF_ID_Rs2Used_i),
    .match    (reg_match)
  );

  // Hazard qualification and stall decision. In LD_STALL the bubble already
  // occupies ID/EX, so detection is not consulted there.
  always_comb begin
    hit   = ID_EX_MemRead_i && reg_match;
    stall = !DMem_Busy_i && ((state == LD_STALL) || hit);
  end

  // Prioritised output decode; stall takes effect in the detection cycle.
  always_comb begin
    PCWrite_o     = 1'b1;
    IF_ID_Write_o = 1'b1;
    ID_EX_Flush_o = 1'b0;
    IF_ID_Flush_o = 1'b0;
    Pipe_Freeze_o = 1'b0;
    if (rst_i) begin
      PCWrite_o     = 1'b1;
      IF_ID_Write_o = 1'b1;
    end else if (DMem_Busy_i) begin
      PCWrite_o     = 1'b0;
      IF_ID_Write_o = 1'b0;
      Pipe_Freeze_o = 1'b1;
    end else if (stall) begin
      // A stalled branch's operands are not valid yet, so it is ignored.
      PCWrite_o     = 1'b0;
      IF_ID_Write_o = 1'b0;
      ID_EX_Flush_o = 1'b1;
    end else if (Branch_Taken_i) begin
      IF_ID_Flush_o = 1'b1;
    end else begin
      PCWrite_o     = 1'b1;
      IF_ID_Write_o = 1'b1;
    end
  end

  // Stall FSM, remaining-cycle counter and performance counter. A freeze
  // holds everything so the stall resumes exactly where it stopped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rem       <= '0;
      stall_cnt <= '0;
    end else if (DMem_Busy_i) begin
      state     <= state;
      rem       <= rem;
      stall_cnt <= stall_cnt;
    end else if (state == LD_STALL) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
      if (rem == REM_ONE) begin
        state <= IDLE;
        rem   <= '0;
      end else begin
        rem <= rem - REM_ONE;
      end
    end else if (hit) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
      // The detection cycle is the first stall cycle; LD_STALL covers the rest.
      if (LOAD_LAT > 1) begin
        state <= LD_STALL;
        rem   <= REM_LOAD;
      end else begin
        state <= IDLE;
        rem   <= '0;
      end
    end else begin
      state <= IDLE;
      rem   <= '0;
    end
  end

  assign Stall_Cycles_o = stall_cnt;

endmodule : hazard_stall_ctrl

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Directed bench for hazard_stall_ctrl. Four instances share one stimulus
// bus: LOAD_LAT=1, LOAD_LAT=3, LOAD_LAT=4 (all CNT_W=32) and LOAD_LAT=1 with
// CNT_W=4. Each scenario resets first and checks only its own instance.
// Control outputs are packed as {PCWrite, IF_ID_Write, ID_EX_Flush,
// IF_ID_Flush, Pipe_Freeze}.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  localparam logic [4:0] C_NORMAL = 5'b11000;
  localparam logic [4:0] C_STALL  = 5'b00100;
  localparam logic [4:0] C_FREEZE = 5'b00001;
  localparam logic [4:0] C_BRANCH = 5'b11010;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       rs1_used;
  logic       rs2_used;
  logic       br_taken;
  logic       busy;

  logic [4:0]  ctl_l1, ctl_l3, ctl_l4, ctl_w4;
  logic [31:0] cnt_l1, cnt_l3, cnt_l4;
  logic [3:0]  cnt_w4;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(32)) u_l1 (
    .clk_i(clk), .rst_i(rst), .ID_EX_MemRead_i(mem_read), .ID_EX_RegisterRd_i(rd),
    .IF_ID_RegisterRs1_i(rs1), .IF_ID_RegisterRs2_i(rs2), .IF_ID_Rs1Used_i(rs1_used),
    .IF_ID_Rs2Used_i(rs2_used), .Branch_Taken_i(br_taken), .DMem_Busy_i(busy),
    .PCWrite_o(ctl_l1[4]), .IF_ID_Write_o(ctl_l1[3]), .ID_EX_Flush_o(ctl_l1[2]),
    .IF_ID_Flush_o(ctl_l1[1]), .Pipe_Freeze_o(ctl_l1[0]), .Stall_Cycles_o(cnt_l1));

  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(32)) u_l3 (
    .clk_i(clk), .rst_i(rst), .ID_EX_MemRead_i(mem_read), .ID_EX_RegisterRd_i(rd),
    .IF_ID_RegisterRs1_i(rs1), .IF_ID_RegisterRs2_i(rs2), .IF_ID_Rs1Used_i(rs1_used),
    .IF_ID_Rs2Used_i(rs2_used), .Branch_Taken_i(br_taken), .DMem_Busy_i(busy),
    .PCWrite_o(ctl_l3[4]), .IF_ID_Write_o(ctl_l3[3]), .ID_EX_Flush_o(ctl_l3[2]),
    .IF_ID_Flush_o(ctl_l3[1]), .Pipe_Freeze_o(ctl_l3[0]), .Stall_Cycles_o(cnt_l3));

  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(4), .CNT_W(32)) u_l4 (
    .clk_i(clk), .rst_i(rst), .ID_EX_MemRead_i(mem_read), .ID_EX_RegisterRd_i(rd),
    .IF_ID_RegisterRs1_i(rs1), .IF_ID_RegisterRs2_i(rs2), .IF_ID_Rs1Used_i(rs1_used),
    .IF_ID_Rs2Used_i(rs2_used), .Branch_Taken_i(br_taken), .DMem_Busy_i(busy),
    .PCWrite_o(ctl_l4[4]), .IF_ID_Write_o(ctl_l4[3]), .ID_EX_Flush_o(ctl_l4[2]),
    .IF_ID_Flush_o(ctl_l4[1]), .Pipe_Freeze_o(ctl_l4[0]), .Stall_Cycles_o(cnt_l4));

  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(4)) u_w4 (
    .clk_i(clk), .rst_i(rst), .ID_EX_MemRead_i(mem_read), .ID_EX_RegisterRd_i(rd),
    .IF_ID_RegisterRs1_i(rs1), .IF_ID_RegisterRs2_i(rs2), .IF_ID_Rs1Used_i(rs1_used),
    .IF_ID_Rs2Used_i(rs2_used), .Branch_Taken_i(br_taken), .DMem_Busy_i(busy),
    .PCWrite_o(ctl_w4[4]), .IF_ID_Write_o(ctl_w4[3]), .ID_EX_Flush_o(ctl_w4[2]),
    .IF_ID_Flush_o(ctl_w4[1]), .Pipe_Freeze_o(ctl_w4[0]), .Stall_Cycles_o(cnt_w4));

  // Compare one observed value against its hand-computed expectation.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Advance to the next negedge and apply one input vector.
  task automatic step(input logic r, input logic mr, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2,
                      input logic u1, input logic u2, input logic br, input logic bz);
    @(negedge clk);
    rst = r; mem_read = mr; rd = d; rs1 = s1; rs2 = s2;
    rs1_used = u1; rs2_used = u2; br_taken = br; busy = bz;
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    rs1_used = 1'b0; rs2_used = 1'b0; br_taken = 1'b0; busy = 1'b0;

    // Reset forces normal outputs even with a hit and a busy memory present.
    step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("rst_forces_normal_l1", 32'(ctl_l1), 32'(C_NORMAL));
    check("rst_forces_normal_l3", 32'(ctl_l3), 32'(C_NORMAL));
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_ctl_l1", 32'(ctl_l1), 32'(C_NORMAL));
    check("reset_cnt_l1", cnt_l1, 32'd0);

    // LOAD_LAT=1: exactly one bubble, then normal.
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("l1_stall", 32'(ctl_l1), 32'(C_STALL));
    step(1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("l1_after_stall", 32'(ctl_l1), 32'(C_NORMAL));
    check("l1_cnt_1", cnt_l1, 32'd1);

    // x0 destination and unused rs2 never stall.
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("x0_no_stall", 32'(ctl_l1), 32'(C_NORMAL));
    step(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rs2_unused_no_stall", 32'(ctl_l1), 32'(C_NORMAL));
    step(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    check("rs2_used_stall", 32'(ctl_l1), 32'(C_STALL));
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("l1_cnt_2", cnt_l1, 32'd2);

    // Stall wins over a taken branch; a lone branch flushes IF/ID.
    step(1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("stall_over_branch", 32'(ctl_l1), 32'(C_STALL));
    step(1'b0, 1'b0, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("branch_alone", 32'(ctl_l1), 32'(C_BRANCH));
    // Busy with a hit present: freeze only, no detection.
    step(1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("busy_over_hit", 32'(ctl_l1), 32'(C_FREEZE));
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("l1_cnt_3", cnt_l1, 32'd3);

    // LOAD_LAT=3 with a 2-cycle freeze in place of the 2nd stall cycle.
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd6, 5'd0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    check("l3_stall_1", 32'(ctl_l3), 32'(C_STALL));
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("l3_freeze_1", 32'(ctl_l3), 32'(C_FREEZE));
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("l3_freeze_2", 32'(ctl_l3), 32'(C_FREEZE));
    check("l3_cnt_held", cnt_l3, 32'd1);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("l3_stall_2_ignores_branch", 32'(ctl_l3), 32'(C_STALL));
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("l3_stall_3", 32'(ctl_l3), 32'(C_STALL));
    // Back-to-back load immediately after returning to IDLE.
    step(1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("l3_cnt_3", cnt_l3, 32'd3);
    check("l3_back_to_back", 32'(ctl_l3), 32'(C_STALL));
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("l3_normal_end", 32'(ctl_l3), 32'(C_NORMAL));
    check("l3_cnt_6", cnt_l3, 32'd6);

    // LOAD_LAT=4, reset asserted in the 2nd stall cycle aborts the stall.
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("l4_stall_1", 32'(ctl_l4), 32'(C_STALL));
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("l4_rst_forces_normal", 32'(ctl_l4), 32'(C_NORMAL));
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("l4_after_rst", 32'(ctl_l4), 32'(C_NORMAL));
    check("l4_cnt_0", cnt_l4, 32'd0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("l4_idle_branch", 32'(ctl_l4), 32'(C_BRANCH));

    // CNT_W=4 counter wraps after 16 stall cycles.
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, 5'd2, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 5'd2, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("w4_stall_16", 32'(ctl_w4), 32'(C_STALL));
    check("w4_cnt_15", 32'(cnt_w4), 32'd15);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("w4_cnt_wrap", 32'(cnt_w4), 32'd0);
    check("w4_normal", 32'(ctl_w4), 32'(C_NORMAL));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_hazard_stall_ctrl
